// File: rtl/ram_port0_arbiter.sv
// ram_port0_arbiter
// Shares the read/write port 0 of ram_dual_port between two requesters.
// Each transaction is a fixed IDLE -> CMD -> CAPT -> RESP sequence.
// The SRAM command signals are driven from registers for exactly one cycle.
// The SRAM read data is captured once and held for the owning requester.
// The companion checker module holds the protocol assertions for this block.

module ram_port0_arbiter_chk (
  input logic       clk0,
  input logic       rst_n,
  input logic [1:0] req_ready,
  input logic [1:0] rsp_valid,
  input logic       csb0
);

  // At most one requester sees a response at a time.
  a_rsp_onehot: assert property (@(posedge clk0) disable iff (!rst_n)
    $onehot0(rsp_valid))
    else $error("ram_port0_arbiter: rsp_valid not one-hot");

  // At most one requester is offered a grant.
  a_ready_onehot: assert property (@(posedge clk0) disable iff (!rst_n)
    $onehot0(req_ready))
    else $error("ram_port0_arbiter: req_ready not one-hot");

  // Chip select is never asserted on two consecutive cycles.
  a_no_back_to_back: assert property (@(posedge clk0) disable iff (!rst_n)
    !csb0 |=> csb0)
    else $error("ram_port0_arbiter: back-to-back SRAM command");

  // A grant is never offered while a response is still pending.
  a_no_ready_in_resp: assert property (@(posedge clk0) disable iff (!rst_n)
    (rsp_valid != 2'b00) |-> (req_ready == 2'b00))
    else $error("ram_port0_arbiter: grant offered during response");

endmodule

module ram_port0_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) (
  input  logic                    clk0,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*NUM_WMASKS-1:0] req_wmask,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    csb0,
  output logic                    web0,
  output logic [NUM_WMASKS-1:0]   wmask0,
  output logic [ADDR_WIDTH-1:0]   addr0,
  output logic [DATA_WIDTH-1:0]   din0,
  input  logic [DATA_WIDTH-1:0]   dout0
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   owner_r;
  logic                   owner_nxt_s;
  logic                   last_grant_r;
  logic                   last_grant_nxt_s;
  logic                   we_r;
  logic                   we_nxt_s;
  logic                   csb0_r;
  logic                   csb0_nxt_s;
  logic                   web0_r;
  logic                   web0_nxt_s;
  logic [NUM_WMASKS-1:0]  wmask0_r;
  logic [NUM_WMASKS-1:0]  wmask0_nxt_s;
  logic [ADDR_WIDTH-1:0]  addr0_r;
  logic [ADDR_WIDTH-1:0]  addr0_nxt_s;
  logic [DATA_WIDTH-1:0]  din0_r;
  logic [DATA_WIDTH-1:0]  din0_nxt_s;
  logic [1:0]             rsp_valid_r;
  logic [1:0]             rsp_valid_nxt_s;
  logic [DATA_WIDTH-1:0]  rsp_rdata_r;
  logic [DATA_WIDTH-1:0]  rsp_rdata_nxt_s;

  logic                   winner_s;
  logic [1:0]             grant_s;
  logic                   sel_we_s;
  logic [NUM_WMASKS-1:0]  sel_wmask_s;
  logic [ADDR_WIDTH-1:0]  sel_addr_s;
  logic [DATA_WIDTH-1:0]  sel_wdata_s;

  // Round-robin winner: under contention the requester not served last goes next.
  always_comb begin
    winner_s = 1'b0;
    grant_s  = 2'b00;
    if (req_valid == 2'b11) begin
      winner_s = ~last_grant_r;
    end else if (req_valid == 2'b10) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    if ((state_r == ST_IDLE) && (req_valid != 2'b00)) begin
      grant_s = winner_s ? 2'b10 : 2'b01;
    end else begin
      grant_s = 2'b00;
    end
  end

  // Steer the winning requester's command fields onto the SRAM path.
  always_comb begin
    if (winner_s) begin
      sel_we_s    = req_we[1];
      sel_wmask_s = req_wmask[NUM_WMASKS +: NUM_WMASKS];
      sel_addr_s  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
      sel_wdata_s = req_wdata[DATA_WIDTH +: DATA_WIDTH];
    end else begin
      sel_we_s    = req_we[0];
      sel_wmask_s = req_wmask[0 +: NUM_WMASKS];
      sel_addr_s  = req_addr[0 +: ADDR_WIDTH];
      sel_wdata_s = req_wdata[0 +: DATA_WIDTH];
    end
  end

  // Transaction sequencer: next state and next values of every registered output.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    last_grant_nxt_s = last_grant_r;
    we_nxt_s         = we_r;
    csb0_nxt_s       = csb0_r;
    web0_nxt_s       = web0_r;
    wmask0_nxt_s     = wmask0_r;
    addr0_nxt_s      = addr0_r;
    din0_nxt_s       = din0_r;
    rsp_valid_nxt_s  = rsp_valid_r;
    rsp_rdata_nxt_s  = rsp_rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          state_nxt_s      = ST_CMD;
          owner_nxt_s      = winner_s;
          last_grant_nxt_s = winner_s;
          we_nxt_s         = sel_we_s;
          csb0_nxt_s       = 1'b0;
          web0_nxt_s       = ~sel_we_s;
          wmask0_nxt_s     = sel_wmask_s;
          addr0_nxt_s      = sel_addr_s;
          din0_nxt_s       = sel_wdata_s;
        end else begin
          state_nxt_s      = ST_IDLE;
        end
      end
      ST_CMD: begin
        // The SRAM latches the command on this edge; release it immediately.
        csb0_nxt_s  = 1'b1;
        web0_nxt_s  = 1'b1;
        state_nxt_s = ST_CAPT;
      end
      ST_CAPT: begin
        // dout0 settled after the SRAM's negedge access inside this cycle.
        if (we_r) begin
          rsp_rdata_nxt_s = {DATA_WIDTH{1'b0}};
        end else begin
          rsp_rdata_nxt_s = dout0;
        end
        rsp_valid_nxt_s = owner_r ? 2'b10 : 2'b01;
        state_nxt_s     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_r]) begin
          rsp_valid_nxt_s = 2'b00;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s     = ST_RESP;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        csb0_nxt_s      = 1'b1;
        web0_nxt_s      = 1'b1;
        rsp_valid_nxt_s = 2'b00;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      csb0_r       <= 1'b1;
      web0_r       <= 1'b1;
      wmask0_r     <= {NUM_WMASKS{1'b0}};
      addr0_r      <= {ADDR_WIDTH{1'b0}};
      din0_r       <= {DATA_WIDTH{1'b0}};
      rsp_valid_r  <= 2'b00;
      rsp_rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      we_r         <= we_nxt_s;
      csb0_r       <= csb0_nxt_s;
      web0_r       <= web0_nxt_s;
      wmask0_r     <= wmask0_nxt_s;
      addr0_r      <= addr0_nxt_s;
      din0_r       <= din0_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rsp_rdata_r  <= rsp_rdata_nxt_s;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign csb0      = csb0_r;
  assign web0      = web0_r;
  assign wmask0    = wmask0_r;
  assign addr0     = addr0_r;
  assign din0      = din0_r;

  ram_port0_arbiter_chk u_chk (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .csb0      (csb0)
  );

endmodule
